mem_copy_engine: RTL and testbench

Block-copy initiator that drives the data memory's single port (`DataAddr`, `MemWrite`, `DataIn`, `DataOut`) to copy `len` bytes from a source address to a destination address. It sits in front of `datamem` as an alternate master, and the top level muxes its memory-side ports with the core's whenever `busy` is high. It uses a start/busy/done handshake and a read-then-write loop of two cycles per byte.

---
 rtl/mem_copy_pkg.sv | 18 +
 rtl/mem_copy_engine.sv | 116 +++++++++++
 tb/tb_mem_copy_engine.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_copy_pkg.sv
// Shared types and constants for the block-copy engine.
// Holds the FSM state encoding, default widths and pointer steps.
package mem_copy_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  localparam int STEP_UP = 1;
  localparam int STEP_DN = -1;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// Byte block-copy master for the data memory port, two cycles per byte.
// Define MEM_COPY_OVERLAP_EN for memmove-safe descending overlap copies.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] DataAddr,
  output logic          MemWrite,
  output logic [DW-1:0] DataIn,
  input  logic [DW-1:0] DataOut
);

  state_t        state;
  logic [AW-1:0] sp;
  logic [AW-1:0] dp;
  logic [AW-1:0] cnt;
  logic [DW-1:0] data_buf;
  logic          down;

  logic [AW-1:0] step;
  logic [AW-1:0] sp_nx;
  logic [AW-1:0] tail;
  logic [AW-1:0] sp_init;
  logic [AW-1:0] dp_init;
  logic          ovl;

`ifdef MEM_COPY_OVERLAP_EN
  logic [AW-1:0] gap;
  // dst lands inside the source window: copy from the top down
  assign gap = dst_addr - src_addr;
  assign ovl = (gap != '0) && (gap < len);
`else
  assign ovl = 1'b0;
`endif

  assign step    = down ? AW'(STEP_DN) : AW'(STEP_UP);
  assign sp_nx   = sp + step;
  assign tail    = len - AW'(1);
  assign sp_init = ovl ? src_addr + tail : src_addr;
  assign dp_init = ovl ? dst_addr + tail : dst_addr;

  // data_buf is cleared outside WR so it doubles as the write-data port
  assign DataIn = data_buf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sp       <= '0;
      dp       <= '0;
      cnt      <= '0;
      down     <= 1'b0;
      data_buf <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      MemWrite <= 1'b0;
      DataAddr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sp   <= sp_init;
            dp   <= dp_init;
            cnt  <= len;
            down <= ovl;
            busy <= 1'b1;
            if (len != '0) begin
              state    <= RD;
              DataAddr <= sp_init;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RD: begin
          data_buf <= DataOut;
          state    <= WR;
          DataAddr <= dp;
          MemWrite <= 1'b1;
        end
        WR: begin
          sp       <= sp_nx;
          dp       <= dp + step;
          cnt      <= cnt - AW'(1);
          MemWrite <= 1'b0;
          data_buf <= '0;
          if (cnt == AW'(1)) begin
            state    <= DONE;
            done     <= 1'b1;
            DataAddr <= '0;
          end else begin
            state    <= RD;
            DataAddr <= sp_nx;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine against a byte-array copy model.
// Build with MEM_COPY_OVERLAP_EN to check the memmove variant.
module tb_mem_copy_engine;

`ifdef MEM_COPY_OVERLAP_EN
  localparam bit OVL_EN = 1'b1;
`else
  localparam bit OVL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] src_addr;
  logic [7:0] dst_addr;
  logic [7:0] len;
  logic       busy;
  logic       done;
  logic [7:0] DataAddr;
  logic       MemWrite;
  logic [7:0] DataIn;
  logic [7:0] DataOut;

  logic [7:0] mem  [256];
  logic [7:0] refm [256];
  logic       pk = 1'b0;
  logic [7:0] pk_a;
  logic [7:0] pk_d;

  int checks = 0;
  int errors = 0;

  mem_copy_engine dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .DataAddr (DataAddr),
    .MemWrite (MemWrite),
    .DataIn   (DataIn),
    .DataOut  (DataOut)
  );

  always #5 clk = ~clk;

  assign DataOut = mem[DataAddr];

  // single writer for the memory: bench preload or DUT write
  always @(posedge clk or posedge pk) begin
    if (pk) mem[pk_a] = pk_d;
    else if (MemWrite) mem[DataAddr] = DataIn;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] v);
    refm[a] = v;
    pk_a = a;
    pk_d = v;
    pk = 1'b1;
    #1;
    pk = 1'b0;
    #1;
  endtask

  function automatic bit ovl(input logic [7:0] s,
                             input logic [7:0] d,
                             input logic [7:0] l);
    logic [7:0] g;
    g = d - s;
    return OVL_EN && (d != s) && (g < l);
  endfunction

  // Reference: memmove from the top when overlapping, else a plain
  // forward byte loop (which smears an overlapping dst>src copy).
  task automatic ref_copy(input logic [7:0] s,
                          input logic [7:0] d,
                          input logic [7:0] l);
    int n;
    n = l;
    if (ovl(s, d, l)) begin
      for (int k = n - 1; k >= 0; k--)
        refm[8'(d + k)] = refm[8'(s + k)];
    end else begin
      for (int k = 0; k < n; k++)
        refm[8'(d + k)] = refm[8'(s + k)];
    end
  endtask

  task automatic mem_cmp(input string tag);
    int mis;
    mis = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== refm[i]) mis++;
    chk(tag, mis, 0);
  endtask

  task automatic run_copy(input logic [7:0] s,
                          input logic [7:0] d,
                          input logic [7:0] l,
                          input int pulse_cyc);
    logic [7:0] ea;
    bit dn;
    bit pw;
    int n, k, wr, dc;
    n = l;
    dn = ovl(s, d, l);
    ref_copy(s, d, l);
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    len = l;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wr = 0;
    dc = 0;
    pw = 1'b0;
    for (int c = 1; c <= 2 * n + 3 && dc == 0; c++) begin
      if (c == pulse_cyc) begin
        start = 1'b1;
        src_addr = 8'h70;
        dst_addr = 8'h90;
        len = 8'd5;
      end else begin
        start = 1'b0;
      end
      chk("busy", busy, 1);
      chk("done", done, c == 2 * n + 1);
      chk("mw_pair", pw & MemWrite, 0);
      pw = MemWrite;
      if (MemWrite) wr++;
      if (c <= 2 * n) begin
        k = (c - 1) / 2;
        if (c % 2 == 1) begin
          ea = dn ? 8'(s + n - 1 - k) : 8'(s + k);
          chk("rd_mw", MemWrite, 0);
          chk("rd_addr", DataAddr, ea);
        end else begin
          ea = dn ? 8'(d + n - 1 - k) : 8'(d + k);
          chk("wr_mw", MemWrite, 1);
          chk("wr_addr", DataAddr, ea);
        end
      end else begin
        chk("done_addr", DataAddr, 0);
        chk("done_mw", MemWrite, 0);
      end
      if (done) dc = c;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk("done_cyc", dc, 2 * n + 1);
    chk("n_writes", wr, n);
    chk("busy_after", busy, 0);
    chk("done_after", done, 0);
    mem_cmp("mem");
  endtask

  initial begin : main
    logic [7:0] old;
    logic [7:0] e4 [4];
    int act;

    reset = 1'b1;
    start = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    len = '0;
    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mw", MemWrite, 0);
    chk("rst_addr", DataAddr, 0);
    chk("rst_din", DataIn, 0);
    @(negedge clk);
    reset = 1'b0;

    // plain copy
    poke(8'h10, 8'hA1);
    poke(8'h11, 8'hB2);
    poke(8'h12, 8'hC3);
    poke(8'h13, 8'hD4);
    run_copy(8'h10, 8'h40, 8'd4, 0);
    chk("cp0", mem[8'h40], 8'hA1);
    chk("cp1", mem[8'h41], 8'hB2);
    chk("cp2", mem[8'h42], 8'hC3);
    chk("cp3", mem[8'h43], 8'hD4);

    // zero length
    run_copy(8'h33, 8'h44, 8'd0, 0);

    // wrap across the top of memory
    poke(8'hFE, 8'h5A);
    poke(8'hFF, 8'h6B);
    poke(8'h00, 8'h7C);
    run_copy(8'hFE, 8'h20, 8'd3, 0);
    chk("wr0", mem[8'h20], 8'h5A);
    chk("wr1", mem[8'h21], 8'h6B);
    chk("wr2", mem[8'h22], 8'h7C);

    // overlapping dst > src
    for (int i = 0; i < 4; i++) poke(8'(8'h10 + i), 8'(i + 1));
    run_copy(8'h10, 8'h11, 8'd4, 0);
    if (OVL_EN) begin
      e4[0] = 8'd1; e4[1] = 8'd2; e4[2] = 8'd3; e4[3] = 8'd4;
    end else begin
      e4[0] = 8'd1; e4[1] = 8'd1; e4[2] = 8'd1; e4[3] = 8'd1;
    end
    for (int i = 0; i < 4; i++)
      chk("ovl", mem[8'(8'h11 + i)], e4[i]);

    // src == dst leaves memory untouched
    run_copy(8'h55, 8'h55, 8'd3, 0);

    // reset during the fourth WR of an 8-byte copy
    for (int i = 0; i < 8; i++) poke(8'(8'hA0 + i), 8'(8'hE0 + i));
    old = mem[8'hA3];
    @(negedge clk);
    src_addr = 8'h60;
    dst_addr = 8'hA0;
    len = 8'd8;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("rst_in_wr", MemWrite, 1);
    reset = 1'b1;
    #1;
    chk("rst_mw_drop", MemWrite, 0);
    chk("rst_busy_drop", busy, 0);
    chk("rst_done_low", done, 0);
    chk("rst_addr_drop", DataAddr, 0);
    @(negedge clk);
    reset = 1'b0;
    act = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (busy || done || MemWrite) act++;
    end
    chk("rst_quiet", act, 0);
    chk("rst_keep", mem[8'hA3], old);
    for (int k = 0; k < 3; k++)
      refm[8'(8'hA0 + k)] = refm[8'(8'h60 + k)];
    mem_cmp("rst_mem");

    // start pulsed while busy is ignored
    for (int i = 0; i < 5; i++) begin
      poke(8'(8'h70 + i), 8'(8'h11 * (i + 1)));
      poke(8'(8'h90 + i), 8'(8'hF0 - i));
    end
    run_copy(8'h30, 8'h50, 8'd2, 2);
    act = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (busy || MemWrite) act++;
    end
    chk("no_queue", act, 0);
    mem_cmp("no_queue_mem");

    // randomized copies
    for (int t = 0; t < 6; t++)
      run_copy(8'($urandom), 8'($urandom),
               8'($urandom_range(0, 24)), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
